fp_normalize_pack: RTL

- Back end of the vector floating-point pipeline, and the counterpart of the front-end unpack/align stage.
- Takes per-lane unpacked results (magnitude significand, biased exponent, sign, NaN/Inf flags) and produces packed IEEE-754 float32 words.
- Per lane: leading-one detect, normalize shift, round-to-nearest-even, exponent adjust, overflow/underflow handling, pack.
- Two-stage pipeline with a global stall; feeds writeback.

---
 rtl/fp_normalize_pack_pkg.sv | 29 ++
 rtl/fp_normalize_pack_if.sv | 36 +++
 rtl/fp_normalize_pack_lzc.sv | 14 +
 rtl/fp_normalize_pack.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fp_normalize_pack_pkg.sv
// Shared types and constants for the float32 normalize/pack back end.
package fp_normalize_pack_pkg;

  localparam int NUM_VECTOR_LANES   = 16;
  localparam int FLOAT32_EXP_WIDTH  = 8;
  localparam int FLOAT32_SIG_WIDTH  = 23;
  localparam int FP_GUARD_BITS      = 3;
  localparam int FP_NORM_POS        = 26;

  typedef struct packed {
    logic                         sign;
    logic [FLOAT32_EXP_WIDTH-1:0] exponent;
    logic [FLOAT32_SIG_WIDTH-1:0] significand;
  } float32_t;

  typedef logic [3:0]                  local_thread_idx_t;
  typedef logic [NUM_VECTOR_LANES-1:0] vector_lane_mask_t;

  // Stage A per-lane state; exp is a two's-complement 10-bit value.
  typedef struct packed {
    logic [31:0] sig;
    logic [9:0]  exp;
    logic        sign;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
  } lane_a_t;

endpackage

// File: rtl/fp_normalize_pack_if.sv
// Lane bus between the FP datapath, the normalize/pack stage and writeback.
interface fp_normalize_pack_if
  import fp_normalize_pack_pkg::*;
#(
  parameter int NUM_LANES = NUM_VECTOR_LANES
) ();

  logic                       stall;
  logic                       in_valid;
  local_thread_idx_t          in_thread_idx;
  vector_lane_mask_t          in_mask;
  logic [NUM_LANES-1:0][31:0] in_significand;
  logic [NUM_LANES-1:0][7:0]  in_exponent;
  logic [NUM_LANES-1:0]       in_sign;
  logic [NUM_LANES-1:0]       in_is_nan;
  logic [NUM_LANES-1:0]       in_is_inf;
  logic                       in_is_int;

  logic                       out_valid;
  local_thread_idx_t          out_thread_idx;
  vector_lane_mask_t          out_mask;
  logic [NUM_LANES-1:0][31:0] out_result;

  modport master (
    output stall, in_valid, in_thread_idx, in_mask, in_significand,
           in_exponent, in_sign, in_is_nan, in_is_inf, in_is_int,
    input  out_valid, out_thread_idx, out_mask, out_result
  );

  modport slave (
    input  stall, in_valid, in_thread_idx, in_mask, in_significand,
           in_exponent, in_sign, in_is_nan, in_is_inf, in_is_int,
    output out_valid, out_thread_idx, out_mask, out_result
  );

endinterface

// File: rtl/fp_normalize_pack_lzc.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module fp_lzc32 (
  input  logic [31:0] in_val,
  output logic [5:0]  lz_cnt
);

  always_comb begin
    lz_cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (in_val[i]) lz_cnt = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_pack.sv
// Per-lane normalize, round-to-nearest-even and float32 pack; 2-cycle latency, global stall holds both stages.
// FP_DENORMAL_EN selects gradual underflow; otherwise tiny results flush to signed zero.
module fp_normalize_pack
  import fp_normalize_pack_pkg::*;
#(
  parameter int          NUM_LANES     = NUM_VECTOR_LANES,
  parameter logic [31:0] CANONICAL_NAN = 32'h7fffffff
) (
  input logic                clk,
  input logic                reset,
  fp_normalize_pack_if.slave bus
);

  localparam logic [4:0] NORM_POS5 = 5'(FP_NORM_POS);

  lane_a_t [NUM_LANES-1:0]    a_lane_new, a_lane_d, a_lane_q;
  logic                       a_vld_d, a_vld_q;
  logic                       a_int_d, a_int_q;
  local_thread_idx_t          a_thread_d, a_thread_q;
  vector_lane_mask_t          a_mask_d, a_mask_q;

  logic [NUM_LANES-1:0][31:0] res_new, res_d, res_q;
  logic                       b_vld_d, b_vld_q;
  local_thread_idx_t          b_thread_d, b_thread_q;
  vector_lane_mask_t          b_mask_d, b_mask_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [5:0]  lz_cnt;
    logic [4:0]  lead;
    logic [4:0]  sh;
    logic [26:0] nrm;
    logic        sticky;
    logic [9:0]  exp_n;
    lane_a_t     lane_new;

    logic [25:0] b_frac;
    logic        rnd;
    logic [23:0] fsum;
    logic [9:0]  exp_r;
    logic [31:0] res;
`ifdef FP_DENORMAL_EN
    logic [9:0]  dsh_full;
    logic [4:0]  dsh;
    logic [53:0] den_wide;
    logic [26:0] den;
    logic        drnd;
    logic [23:0] dsum;
`endif

    fp_lzc32 u_lzc (
      .in_val (bus.in_significand[g]),
      .lz_cnt (lz_cnt)
    );

    // Stage A: bring the leading one to bit 26, folding lost bits into sticky.
    always_comb begin
      lead   = 5'd31 - lz_cnt[4:0];
      sh     = '0;
      nrm    = '0;
      sticky = 1'b0;
      exp_n  = {2'b00, bus.in_exponent[g]};
      if (lead > NORM_POS5) begin
        sh     = lead - NORM_POS5;
        nrm    = 27'(bus.in_significand[g] >> sh);
        sticky = |(bus.in_significand[g] & ~(32'hffffffff << sh));
        exp_n  = {2'b00, bus.in_exponent[g]} + {5'd0, sh};
      end else begin
        sh     = NORM_POS5 - lead;
        nrm    = 27'(bus.in_significand[g] << sh);
        exp_n  = {2'b00, bus.in_exponent[g]} - {5'd0, sh};
      end
      lane_new.sig     = bus.in_is_int ? bus.in_significand[g]
                                       : {5'd0, nrm[26:1], nrm[0] | sticky};
      lane_new.exp     = exp_n;
      lane_new.sign    = bus.in_sign[g];
      lane_new.is_nan  = bus.in_is_nan[g];
      lane_new.is_inf  = bus.in_is_inf[g];
      lane_new.is_zero = lz_cnt[5];
    end

    assign a_lane_new[g] = lane_new;

    // Stage B: round the 23-bit fraction; a carry out leaves fraction zero.
    always_comb begin
      b_frac = a_lane_q[g].sig[25:0];
      rnd    = b_frac[2] & (b_frac[1] | b_frac[0] | b_frac[3]);
      fsum   = {1'b0, b_frac[25:3]} + {23'd0, rnd};
      exp_r  = a_lane_q[g].exp + {9'd0, fsum[23]};
`ifdef FP_DENORMAL_EN
      dsh_full = 10'd1 - a_lane_q[g].exp;
      dsh      = ($signed(dsh_full) > 10'sd27) ? 5'd27 : dsh_full[4:0];
      den_wide = {a_lane_q[g].sig[26:0], 27'd0} >> dsh;
      den      = {den_wide[53:28], den_wide[27] | (|den_wide[26:0])};
      drnd     = den[2] & (den[1] | den[0] | den[3]);
      dsum     = den[26:3] + {23'd0, drnd};
`endif
      if (a_int_q) begin
        res = a_lane_q[g].sig;
      end else if (a_lane_q[g].is_nan) begin
        res = CANONICAL_NAN;
      end else if (a_lane_q[g].is_inf || ($signed(exp_r) >= 10'sd255)) begin
        res = {a_lane_q[g].sign, 8'hff, 23'd0};
      end else if (a_lane_q[g].is_zero) begin
        res = {a_lane_q[g].sign, 31'd0};
      end else if ($signed(exp_r) <= 10'sd0) begin
`ifdef FP_DENORMAL_EN
        // A round into the hidden bit lands on exponent field 1 by construction.
        res = {a_lane_q[g].sign, 7'd0, dsum};
`else
        res = {a_lane_q[g].sign, 31'd0};
`endif
      end else begin
        res = {a_lane_q[g].sign, exp_r[7:0], fsum[22:0]};
      end
    end

    assign res_new[g] = res;
  end

  always_comb begin
    a_vld_d    = a_vld_q;
    a_int_d    = a_int_q;
    a_thread_d = a_thread_q;
    a_mask_d   = a_mask_q;
    a_lane_d   = a_lane_q;
    b_vld_d    = b_vld_q;
    b_thread_d = b_thread_q;
    b_mask_d   = b_mask_q;
    res_d      = res_q;
    if (!bus.stall) begin
      a_vld_d    = bus.in_valid;
      a_int_d    = bus.in_is_int;
      a_thread_d = bus.in_thread_idx;
      a_mask_d   = bus.in_mask;
      a_lane_d   = a_lane_new;
      b_vld_d    = a_vld_q;
      b_thread_d = a_thread_q;
      b_mask_d   = a_mask_q;
      res_d      = res_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_vld_q    <= 1'b0;
      a_int_q    <= 1'b0;
      a_thread_q <= '0;
      a_mask_q   <= '0;
      a_lane_q   <= '0;
      b_vld_q    <= 1'b0;
      b_thread_q <= '0;
      b_mask_q   <= '0;
      res_q      <= '0;
    end else begin
      a_vld_q    <= a_vld_d;
      a_int_q    <= a_int_d;
      a_thread_q <= a_thread_d;
      a_mask_q   <= a_mask_d;
      a_lane_q   <= a_lane_d;
      b_vld_q    <= b_vld_d;
      b_thread_q <= b_thread_d;
      b_mask_q   <= b_mask_d;
      res_q      <= res_d;
    end
  end

  assign bus.out_valid      = b_vld_q;
  assign bus.out_thread_idx = b_thread_q;
  assign bus.out_mask       = b_mask_q;
  assign bus.out_result     = res_q;

endmodule
